// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache line-fill path.
// Line geometry and field positions are common to the cache and its fill controller.
package icache_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int WORD_WIDTH = 32;
    localparam int LINE_WORDS = 8;
    localparam int WORD_OFF_W = 3;

    // Byte address = {line address, word offset, byte offset}
    localparam int LINE_HI = 31;
    localparam int LINE_LO = 5;
    localparam int WORD_HI = 4;
    localparam int WORD_LO = 2;
    localparam int LINE_W  = LINE_HI - LINE_LO + 1;

    localparam logic [WORD_OFF_W-1:0] LAST_WORD = WORD_OFF_W'(LINE_WORDS - 1);

    localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } fill_state_t;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(
        input logic [LINE_W-1:0]     line,
        input logic [WORD_OFF_W-1:0] idx
    );
        return {line, idx, 2'b00};
    endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Eight-word line buffer written one word at a time during a fill.
// Contents persist until overwritten by the next fill.
module icache_line_buf
    import icache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_we,
    input  logic [WORD_OFF_W-1:0] i_idx,
    input  logic [WORD_WIDTH-1:0] i_data,
    output logic [WORD_WIDTH-1:0] o_w0,
    output logic [WORD_WIDTH-1:0] o_w1,
    output logic [WORD_WIDTH-1:0] o_w2,
    output logic [WORD_WIDTH-1:0] o_w3,
    output logic [WORD_WIDTH-1:0] o_w4,
    output logic [WORD_WIDTH-1:0] o_w5,
    output logic [WORD_WIDTH-1:0] o_w6,
    output logic [WORD_WIDTH-1:0] o_w7
);

    logic [WORD_WIDTH-1:0] r_w [LINE_WORDS];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_w[i] <= '0;
            end
        end else if (i_we) begin
            r_w[i_idx] <= i_data;
        end
    end

    assign o_w0 = r_w[0];
    assign o_w1 = r_w[1];
    assign o_w2 = r_w[2];
    assign o_w3 = r_w[3];
    assign o_w4 = r_w[4];
    assign o_w5 = r_w[5];
    assign o_w6 = r_w[6];
    assign o_w7 = r_w[7];

endmodule

// File: rtl/icache_fill_ctrl.sv
// I-cache line-fill controller: stalls fetch, reads an 8-word line, strobes update.
// Optional perf counters (miss_count, fill_cycles) enabled by ICACHE_FILL_PERF_EN.
module icache_fill_ctrl
    import icache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic                  miss,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    input  logic                  mem_err,
    output logic [WORD_WIDTH-1:0] w0,
    output logic [WORD_WIDTH-1:0] w1,
    output logic [WORD_WIDTH-1:0] w2,
    output logic [WORD_WIDTH-1:0] w3,
    output logic [WORD_WIDTH-1:0] w4,
    output logic [WORD_WIDTH-1:0] w5,
    output logic [WORD_WIDTH-1:0] w6,
    output logic [WORD_WIDTH-1:0] w7,
    output logic                  update,
    output logic                  stall,
    output logic                  fill_err
`ifdef ICACHE_FILL_PERF_EN
    ,
    output logic [31:0]           miss_count,
    output logic [31:0]           fill_cycles
`endif
);

    fill_state_t           r_state;
    logic [WORD_OFF_W-1:0] r_cnt;
    logic [LINE_W-1:0]     r_line_base;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_update;
    logic                  r_fill_err;

    logic                  w_start;
    logic                  w_xfer;
    logic                  w_we;
    logic [WORD_OFF_W-1:0] w_cnt_nxt;
    logic                  w_unused_pc;

    assign w_start     = (r_state == IDLE) && miss;
    assign w_xfer      = (r_state == FETCH) && r_mem_req && mem_ack;
    assign w_we        = w_xfer && !mem_err;
    assign w_cnt_nxt   = r_cnt + 3'd1;
    assign w_unused_pc = ^PC[LINE_LO-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_line_base <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_update    <= 1'b0;
            r_fill_err  <= 1'b0;
        end else begin
            r_update   <= 1'b0;
            r_fill_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (miss) begin
                        r_line_base <= PC[LINE_HI:LINE_LO];
                        r_cnt       <= '0;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= word_addr(PC[LINE_HI:LINE_LO], '0);
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (w_xfer) begin
                        if (mem_err) begin
                            // Abort: discard the word, no update
                            r_mem_req  <= 1'b0;
                            r_fill_err <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                            if (r_cnt == LAST_WORD) begin
                                r_mem_req <= 1'b0;
                                r_update  <= 1'b1;
                                r_state   <= WRITE;
                            end else begin
                                r_mem_addr <= word_addr(r_line_base, w_cnt_nxt);
                            end
                        end
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign update   = r_update;
    assign fill_err = r_fill_err;
    assign stall    = (r_state != IDLE) || (miss && !RST);

    icache_line_buf u_line_buf (
        .CLK    (CLK),
        .RST    (RST),
        .i_we   (w_we),
        .i_idx  (r_cnt),
        .i_data (mem_rdata),
        .o_w0   (w0),
        .o_w1   (w1),
        .o_w2   (w2),
        .o_w3   (w3),
        .o_w4   (w4),
        .o_w5   (w5),
        .o_w6   (w6),
        .o_w7   (w7)
    );

`ifdef ICACHE_FILL_PERF_EN
    logic [31:0] r_miss_count;
    logic [31:0] r_fill_cycles;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_miss_count  <= '0;
            r_fill_cycles <= '0;
        end else begin
            if (w_start && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
            if (stall && (r_fill_cycles != 32'hFFFF_FFFF)) begin
                r_fill_cycles <= r_fill_cycles + 32'd1;
            end
        end
    end

    assign miss_count  = r_miss_count;
    assign fill_cycles = r_fill_cycles;
`endif

endmodule
